row_issue_sequencer: RTL and testbench

- Stage directly upstream of the row data bus: accepts a serial operand stream from the tile loader over a valid/ready handshake and buffers it in a small FIFO.
- Issues one element per cycle as a one-hot lane strobe plus lane-aligned data, which is the exact input format of the row broadcast bus.
- Lane pointer walks 0..ARRAY_SIZE-1 and wraps, so successive elements land on successive lanes.
- Tracks matrix boundaries and pulses done after the last element has been issued.

---
 rtl/row_issue_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_row_issue_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/row_issue_sequencer.sv
// row_issue_sequencer
// Buffers a serial operand stream from the tile loader in a small FIFO and
// issues one element per cycle onto the row broadcast bus as a one-hot lane
// strobe with lane-aligned data. Tracks matrix boundaries and completed rows.
module row_issue_sequencer #(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ROW_CNT_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             issue_en,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    output logic [ARRAY_SIZE-1:0]            valid_out,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_out,
    output logic [ROW_CNT_W-1:0]             row_count,
    output logic                             busy,
    output logic                             done
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int LANE_W  = $clog2(ARRAY_SIZE);
    localparam int ENTRY_W = DATA_WIDTH + 1;

    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [LANE_W-1:0]    LANE_ONE = LANE_W'(1);
    localparam logic [LANE_W-1:0]    LANE_MAX = LANE_W'(ARRAY_SIZE - 1);
    localparam logic [ROW_CNT_W-1:0] ROW_ONE  = ROW_CNT_W'(1);
    localparam logic [ROW_CNT_W-1:0] ROW_SAT  = {ROW_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Registered state and its next-state values
    state_t                          state_q,     state_d;
    logic [ENTRY_W-1:0]              mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]                count_q,     count_d;
    logic                            s_ready_q,   s_ready_d;
    logic [LANE_W-1:0]               lane_ptr_q,  lane_ptr_d;
    logic [ROW_CNT_W-1:0]            row_count_q, row_count_d;
    logic [ARRAY_SIZE-1:0]           valid_out_q, valid_out_d;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                            busy_q,      busy_d;
    logic                            done_q,      done_d;

    // Combinational helpers
    logic                  push_s;
    logic                  pop_s;
    logic                  head_last_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  lane_wrap_s;

    // Next-state logic: FIFO bookkeeping, FSM, lane walk and bus formatting
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        lane_ptr_d  = lane_ptr_q;
        row_count_d = row_count_q;
        valid_out_d = '0;
        data_out_d  = '0;
        done_d      = 1'b0;
        lane_wrap_s = 1'b0;

        // s_ready is registered, so a push never depends on this cycle's pop
        push_s      = s_valid && s_ready_q;
        pop_s       = (state_q == ST_RUN) && issue_en && (count_q != '0);
        head_last_s = mem_q[rd_ptr_q][DATA_WIDTH];
        head_data_s = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

        if (push_s) begin
            mem_d[wr_ptr_q] = {s_last, s_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    row_count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && head_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop_s) begin
            lane_wrap_s = (lane_ptr_q == LANE_MAX);
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                if (lane_ptr_q == LANE_W'(i)) begin
                    valid_out_d[i]                           = 1'b1;
                    data_out_d[i*DATA_WIDTH +: DATA_WIDTH]   = head_data_s;
                end else begin
                    valid_out_d[i]                           = 1'b0;
                    data_out_d[i*DATA_WIDTH +: DATA_WIDTH]   = '0;
                end
            end
            // Only a full sweep counts as a row; a short final row does not
            if (lane_wrap_s && (row_count_q != ROW_SAT)) begin
                row_count_d = row_count_q + ROW_ONE;
            end else begin
                row_count_d = row_count_q;
            end
            // The last element of a matrix realigns the next matrix to lane 0
            if (lane_wrap_s || head_last_s) begin
                lane_ptr_d = '0;
            end else begin
                lane_ptr_d = lane_ptr_q + LANE_ONE;
            end
            done_d = head_last_s;
        end else begin
            valid_out_d = '0;
            data_out_d  = '0;
        end

        s_ready_d = (count_d < CNT_FULL);
        busy_d    = (state_d != ST_IDLE);
    end

    // State register with synchronous active-low reset that also flushes the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s_ready_q   <= 1'b1;
            lane_ptr_q  <= '0;
            row_count_q <= '0;
            valid_out_q <= '0;
            data_out_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s_ready_q   <= s_ready_d;
            lane_ptr_q  <= lane_ptr_d;
            row_count_q <= row_count_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign row_count = row_count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_row_issue_sequencer.sv
// Scoreboard bench for row_issue_sequencer: stimulus pushes the expected bus
// word for every accepted element; a negedge monitor pops and compares.
module tb_row_issue_sequencer;

    localparam int AS = 16;
    localparam int DW = 16;
    localparam int FD = 4;
    localparam int RW = 8;
    localparam int BW = AS * DW;

    logic          clk = 1'b0;
    logic          rst_n, start, issue_en, s_valid, s_last;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [AS-1:0] valid_out;
    logic [BW-1:0] data_out;
    logic [RW-1:0] row_count;
    logic          busy, done;

    typedef struct packed {
        logic [AS-1:0] v;
        logic [BW-1:0] d;
        logic          dn;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    bit   mon_en     = 1'b0;
    int   model_lane = 0;
    int   first_cyc  = -1;
    int   done_cyc   = -1;
    int   accept_cyc = 0;
    int   lat_accept = 0;

    row_issue_sequencer #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .issue_en(issue_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .valid_out(valid_out), .data_out(data_out), .row_count(row_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe on the bus must match the oldest expected word
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out !== '0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got valid_out %0h expected none", valid_out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("valid_out", BW'(valid_out), BW'(mon_e.v));
                    chk("data_out", data_out, mon_e.d);
                    chki("done_flag", int'(done), int'(mon_e.dn));
                    if (first_cyc < 0) first_cyc = cyc;
                    if (done === 1'b1) done_cyc = cyc;
                end
            end else begin
                chk("idle_data_out", data_out, '0);
                chki("idle_done", int'(done), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int   t;
        exp_t e;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        while (s_ready !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready %b expected 1 within 200 cycles", s_ready);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end else begin
            e.v  = AS'(1) << model_lane;
            e.d  = BW'(d) << (model_lane * DW);
            e.dn = l;
            sb.push_back(e);
            if (l) model_lane = 0;
            else   model_lane = (model_lane + 1) % AS;
            tick();
            accept_cyc = cyc;
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        chki(name, sb.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; issue_en = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) tick();
        chki("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", data_out, '0);
        chki("rst_row_count", int'(row_count), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_s_ready", int'(s_ready), 1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // T1: one full row, last on lane 15
        issue_en = 1'b1;
        pulse_start();
        chki("t1_busy", int'(busy), 1);
        first_cyc = -1;
        done_cyc  = -1;
        for (int i = 1; i <= 16; i++) begin
            send(DW'(i), (i == 16));
            if (i == 1) lat_accept = accept_cyc;
        end
        drain("t1_drain");
        chki("t1_row_count", int'(row_count), 1);
        chki("t1_latency", first_cyc, lat_accept + 1);
        chki("t1_span", done_cyc - first_cyc, 15);
        chki("t1_busy_after", int'(busy), 0);

        // T2: 20 elements, partial second row not counted
        pulse_start();
        for (int i = 1; i <= 20; i++) send(DW'(16'h0200 + i), (i == 20));
        drain("t2_drain");
        chki("t2_row_count", int'(row_count), 1);

        // T3: prefetch in IDLE, then start
        for (int i = 1; i <= 4; i++) send(DW'(16'h0300 + i), (i == 4));
        chki("t3_s_ready_full", int'(s_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chki("t3_idle_valid", int'(valid_out), 0);
            chki("t3_idle_busy", int'(busy), 0);
        end
        pulse_start();
        drain("t3_drain");
        chki("t3_s_ready_back", int'(s_ready), 1);

        // T4: issue_en toggling against a full FIFO
        issue_en = 1'b0;
        pulse_start();
        for (int i = 1; i <= 4; i++) send(DW'(16'h0400 + i), (i == 4));
        for (int i = 0; i < 8; i++) begin
            issue_en = (i % 2 == 0);
            tick();
            chki("t4_valid_pattern", int'(valid_out), (i % 2 == 0) ? (1 << (i / 2)) : 0);
        end
        issue_en = 1'b1;
        drain("t4_drain");

        // T5: reset mid-matrix after lane 5, with entries still buffered
        pulse_start();
        for (int i = 0; i < 6; i++) send(DW'(16'h0500 + i), 1'b0);
        drain("t5_drain_pre");
        issue_en = 1'b0;
        send(16'h05AA, 1'b0);
        send(16'h05BB, 1'b0);
        rst_n = 1'b0;
        tick();
        chki("t5_rst_valid_out", int'(valid_out), 0);
        chk("t5_rst_data_out", data_out, '0);
        chki("t5_rst_s_ready", int'(s_ready), 1);
        chki("t5_rst_busy", int'(busy), 0);
        chki("t5_rst_row_count", int'(row_count), 0);
        rst_n = 1'b1;
        sb.delete();
        model_lane = 0;
        issue_en = 1'b1;
        pulse_start();
        for (int i = 1; i <= 3; i++) send(DW'(16'h0550 + i), (i == 3));
        drain("t5_drain_post");
        chki("t5_row_count", int'(row_count), 0);

        // T6: start held through RUN, then a fresh matrix
        start = 1'b1;
        tick();
        for (int i = 1; i <= 17; i++) send(DW'(16'h0600 + i), (i == 17));
        start = 1'b0;
        drain("t6_drain");
        chki("t6_row_count", int'(row_count), 1);
        chki("t6_busy_after", int'(busy), 0);
        pulse_start();
        chki("t6_row_count_cleared", int'(row_count), 0);
        for (int i = 1; i <= 3; i++) send(DW'(16'h0700 + i), (i == 3));
        drain("t6_drain2");
        chki("t6_row_count_final", int'(row_count), 0);

        chki("sb_empty_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
